// File: rtl/seq_mul12_if.sv
// Start/done handshake and operand/product bus for the sequential multiplier.
interface seq_mul12_if #(
    parameter int WIDTH = 12
) ();
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_mul12.sv
// Unsigned shift-and-add multiplier, one partial product per clock, with its
// partial-product adder built from rippled 4-bit carry-lookahead slices.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start, ready=1
// BUSY  | one shift-and-add iteration per edge, WIDTH edges total
// DONE  | product valid, done pulses for this single cycle, ready=1
module seq_mul12 #(
    parameter int WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    seq_mul12_if.slave  bus
);
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int NSLICE = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic [NSLICE:0]    carry;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] product_r;
    logic [CW-1:0]      count;
    logic               last;
    logic               accept;
    logic               ready_c;
    logic               busy_c;
    logic               done_c;

    assign addend   = mq[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NSLICE; i++) begin : g_cla
        cla4 u_cla (
            .a    (acc[4*i +: 4]),
            .b    (addend[4*i +: 4]),
            .cin  (carry[i]),
            .s    (sum[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    // {cout, sum, mq} >> 1; the vacated top bit is always zero so it is dropped
    assign shifted = {carry[NSLICE], sum, mq[WIDTH-1:1]};
    assign last    = (count == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy_c = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_c = 1'b1;
                done_c  = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            mq        <= '0;
            acc       <= '0;
            count     <= '0;
            product_r <= '0;
        end else if (accept) begin
            mcand <= bus.a;
            mq    <= bus.b;
            acc   <= '0;
            count <= '0;
        end else if (state == BUSY) begin
            acc   <= shifted[2*WIDTH-1:WIDTH];
            mq    <= shifted[WIDTH-1:0];
            count <= count + CW'(1);
            if (last) begin
                product_r <= shifted;
            end
        end
    end

    assign bus.ready   = ready_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mul12.sv
// Self-checking bench for seq_mul12: vector table plus scoreboard queue,
// followed by hand-written start-handling and reset-abort sequences.
module tb_seq_mul12;
    localparam int W = 12;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;

    seq_mul12_if #(.WIDTH(W)) bus ();

    seq_mul12 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int             n_checks;
    int             n_fail;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_exp;
    vec_t           vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Called 1 time unit after the accepting edge; returns in the done cycle.
    task automatic finish_op(input int poke);
        logic [2*W-1:0] held;
        int edges;
        int busy_cyc;
        bit stable;
        held     = bus.product;
        edges    = 0;
        busy_cyc = 0;
        stable   = 1'b1;
        while (bus.done !== 1'b1 && edges < 40) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.product !== held) stable = 1'b0;
            tick();
            edges++;
            if (edges == poke) begin
                launch(12'hFFF, 12'hFFF);
            end else if (edges == poke + 1) begin
                bus.start = 1'b0;
            end
        end
        check("done_latency", edges, W);
        check("busy_cycles", busy_cyc, W);
        check("product_stable_in_busy", {31'd0, stable}, 32'd1);
        check("ready_in_done", {31'd0, bus.ready}, 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            last_exp = exp_q.pop_front();
            check("product", {8'd0, bus.product}, {8'd0, last_exp});
        end
    endtask

    task automatic after_done();
        tick();
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("product_held", {8'd0, bus.product}, {8'd0, last_exp});
        check("ready_after", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        check("ready_before", {31'd0, bus.ready}, 32'd1);
        exp_q.push_back({12'd0, a} * {12'd0, b});
        launch(a, b);
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        finish_op(poke);
        after_done();
    endtask

    initial begin
        bit done_seen;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{12'd12,  12'd13,  24'h00009C};
        vecs[1] = '{12'hFFF, 12'hFFF, 24'hFFE001};
        vecs[2] = '{12'h000, 12'hABC, 24'h000000};
        vecs[3] = '{12'h001, 12'hABC, 24'h000ABC};
        vecs[4] = '{12'hABC, 12'h001, 24'h000ABC};
        vecs[5] = '{12'h800, 12'h800, 24'h400000};
        vecs[6] = '{12'h123, 12'h456, 24'h04EDC2};
        vecs[7] = '{12'hFFF, 12'h001, 24'h000FFF};
        vecs[8].a   = W'($urandom);
        vecs[8].b   = W'($urandom);
        vecs[8].exp = {12'd0, vecs[8].a} * {12'd0, vecs[8].b};

        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", {8'd0, bus.product}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            check("table_model", {8'd0, vecs[i].exp},
                  {8'd0, {12'd0, vecs[i].a} * {12'd0, vecs[i].b}});
            run_op(vecs[i].a, vecs[i].b, -1);
            check("table_expect", {8'd0, bus.product}, {8'd0, vecs[i].exp});
            repeat ($urandom_range(0, 2)) tick();
        end

        // start during BUSY must be ignored
        run_op(12'd5, 12'd7, 5);
        check("ignored_start_product", {8'd0, bus.product}, 32'h000023);

        // start held in DONE is taken immediately
        exp_q.push_back(24'd54);
        launch(12'd6, 12'd9);
        tick();
        bus.start = 1'b0;
        finish_op(-1);
        exp_q.push_back(24'h00000C);
        launch(12'd3, 12'd4);
        tick();
        bus.start = 1'b0;
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_not_ready", {31'd0, bus.ready}, 32'd0);
        finish_op(-1);
        after_done();

        // reset at the 6th BUSY edge aborts the operation
        launch(12'h800, 12'h800);
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("abort_still_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_product", {8'd0, bus.product}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) done_seen = 1'b1;
            tick();
        end
        check("abort_no_done", {31'd0, done_seen}, 32'd0);
        check("abort_sb_empty", exp_q.size(), 32'd0);
        run_op(12'd2, 12'd3, -1);
        check("post_abort_product", {8'd0, bus.product}, 32'h000006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
